// File: rtl/psram_pkg.sv
// Shared types and defaults for the QSPI PSRAM arbiter and its command sequencer.
package psram_pkg;

   localparam int PSRAM_ADDR_W     = 23;
   localparam int PSRAM_LEN_W      = 6;
   localparam int PSRAM_LCD_BURST  = 16;
   localparam int PSRAM_CE_GAP     = 4;
   localparam int PSRAM_STARVE_MAX = 8;

   typedef enum logic [2:0] {
      WAIT_INIT,
      IDLE,
      ISSUE,
      BUSY,
      GAP
   } arb_state_t;

   typedef enum logic {
      OWN_LCD,
      OWN_MCU
   } owner_t;

endpackage

// File: rtl/psram_arb_pick.sv
// Combinational winner selection for the PSRAM engine: starvation, then urgency,
// then round-robin on a tie, then the lone requester.
module psram_arb_pick
   import psram_pkg::*;
(
   input  logic   lcd_req,
   input  logic   lcd_urgent,
   input  logic   mcu_req,
   input  logic   starved,
   input  owner_t last_owner,
   output logic   valid,
   output owner_t winner,
   output logic   urgent_win
);

   always_comb begin
      valid      = 1'b1;
      winner     = OWN_LCD;
      urgent_win = 1'b0;
      if (mcu_req && starved) begin
         winner = OWN_MCU;
      end else if (lcd_req && lcd_urgent) begin
         winner     = OWN_LCD;
         urgent_win = 1'b1;
      end else if (lcd_req && mcu_req) begin
         winner = (last_owner == OWN_LCD) ? OWN_MCU : OWN_LCD;
      end else if (lcd_req) begin
         winner = OWN_LCD;
      end else if (mcu_req) begin
         winner = OWN_MCU;
      end else begin
         valid = 1'b0;
      end
   end

endmodule

// File: rtl/psram_arbiter.sv
// Shares the QSPI PSRAM command engine between the LCD refresh reader and the MCU.
// Optional grant statistics outputs are enabled with PSRAM_ARB_STATS_EN.
//
// state     | meaning
// WAIT_INIT | PSRAM init sequence running, requests ignored
// IDLE      | pick a winner each cycle, latch command and grant
// ISSUE     | grant held, eng_start launched on the exit edge
// BUSY      | command running, grant and eng_* frozen until eng_done
// GAP       | CE-high recovery, CE_GAP cycles with no grant
module psram_arbiter
   import psram_pkg::*;
#(
   parameter int ADDR_W     = PSRAM_ADDR_W,
   parameter int LEN_W      = PSRAM_LEN_W,
   parameter int LCD_BURST  = PSRAM_LCD_BURST,
   parameter int STARVE_MAX = PSRAM_STARVE_MAX,
   parameter int CE_GAP     = PSRAM_CE_GAP
)(
   input  logic              psram_sclk,
   input  logic              reset,
   input  logic              init_done,
   input  logic              lcd_req,
   input  logic              lcd_urgent,
   input  logic [ADDR_W-1:0] lcd_addr,
   output logic              lcd_gnt,
   input  logic              mcu_req,
   input  logic              mcu_we,
   input  logic [LEN_W-1:0]  mcu_len,
   input  logic [ADDR_W-1:0] mcu_addr,
   output logic              mcu_gnt,
   output logic              eng_start,
   output logic              eng_we,
   output logic [ADDR_W-1:0] eng_addr,
   output logic [LEN_W-1:0]  eng_len,
   input  logic              eng_done
`ifdef PSRAM_ARB_STATS_EN
   ,
   output logic [15:0]       lcd_grant_cnt,
   output logic [15:0]       mcu_grant_cnt,
   output logic [15:0]       urgent_cnt
`endif
);

   localparam int STARVE_W = $clog2(STARVE_MAX + 1);
   // CE_GAP must be at least 1; the counter is loaded with CE_GAP-1 and runs to zero
   localparam int GAP_W    = $clog2(CE_GAP + 1);
   localparam logic [LEN_W-1:0]    LCD_LEN    = LEN_W'(LCD_BURST);
   localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
   localparam logic [GAP_W-1:0]    GAP_LOAD   = GAP_W'(CE_GAP - 1);

   arb_state_t          state_q, state_d;
   owner_t              last_owner_q, last_owner_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                lcd_gnt_d, mcu_gnt_d, start_d, we_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [LEN_W-1:0]    len_d;
   logic                grant_lcd, grant_mcu, grant_urgent;

   logic   starved;
   logic   pick_valid;
   owner_t pick_owner;
   logic   pick_urgent;

   assign starved = (starve_q == STARVE_TOP);

   psram_arb_pick u_pick (
      .lcd_req    (lcd_req),
      .lcd_urgent (lcd_urgent),
      .mcu_req    (mcu_req),
      .starved    (starved),
      .last_owner (last_owner_q),
      .valid      (pick_valid),
      .winner     (pick_owner),
      .urgent_win (pick_urgent)
   );

   always_ff @(posedge psram_sclk or posedge reset) begin
      if (reset) begin
         state_q      <= WAIT_INIT;
         last_owner_q <= OWN_MCU;
         starve_q     <= '0;
         gap_q        <= '0;
         lcd_gnt      <= 1'b0;
         mcu_gnt      <= 1'b0;
         eng_start    <= 1'b0;
         eng_we       <= 1'b0;
         eng_addr     <= '0;
         eng_len      <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         starve_q     <= starve_d;
         gap_q        <= gap_d;
         lcd_gnt      <= lcd_gnt_d;
         mcu_gnt      <= mcu_gnt_d;
         eng_start    <= start_d;
         eng_we       <= we_d;
         eng_addr     <= addr_d;
         eng_len      <= len_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      starve_d     = starve_q;
      gap_d        = gap_q;
      lcd_gnt_d    = lcd_gnt;
      mcu_gnt_d    = mcu_gnt;
      start_d      = 1'b0;
      we_d         = eng_we;
      addr_d       = eng_addr;
      len_d        = eng_len;
      grant_lcd    = 1'b0;
      grant_mcu    = 1'b0;
      grant_urgent = 1'b0;
      case (state_q)
         WAIT_INIT: begin
            if (init_done) state_d = IDLE;
         end
         IDLE: begin
            if (!mcu_req) starve_d = '0;
            if (pick_valid) begin
               state_d = ISSUE;
               if (pick_owner == OWN_LCD) begin
                  lcd_gnt_d    = 1'b1;
                  we_d         = 1'b0;
                  addr_d       = lcd_addr;
                  len_d        = LCD_LEN;
                  grant_lcd    = 1'b1;
                  grant_urgent = pick_urgent;
                  if (mcu_req && !starved) starve_d = starve_q + 1'b1;
               end else begin
                  mcu_gnt_d = 1'b1;
                  we_d      = mcu_we;
                  addr_d    = mcu_addr;
                  len_d     = (mcu_len == '0) ? LEN_W'(1) : mcu_len;
                  starve_d  = '0;
                  grant_mcu = 1'b1;
               end
            end
         end
         ISSUE: begin
            start_d = 1'b1;
            state_d = BUSY;
         end
         BUSY: begin
            if (eng_done) begin
               state_d      = GAP;
               gap_d        = GAP_LOAD;
               last_owner_d = mcu_gnt ? OWN_MCU : OWN_LCD;
               lcd_gnt_d    = 1'b0;
               mcu_gnt_d    = 1'b0;
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = WAIT_INIT;
      endcase
   end

`ifdef PSRAM_ARB_STATS_EN
   always_ff @(posedge psram_sclk or posedge reset) begin
      if (reset) begin
         lcd_grant_cnt <= '0;
         mcu_grant_cnt <= '0;
         urgent_cnt    <= '0;
      end else begin
         if (grant_lcd)    lcd_grant_cnt <= lcd_grant_cnt + 16'd1;
         if (grant_mcu)    mcu_grant_cnt <= mcu_grant_cnt + 16'd1;
         if (grant_urgent) urgent_cnt    <= urgent_cnt + 16'd1;
      end
   end
`else
   logic unused_grant_flags;
   assign unused_grant_flags = grant_lcd ^ grant_mcu ^ grant_urgent;
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed + randomized self-checking bench for psram_arbiter.
module tb_psram_arbiter;

   localparam int ADDR_W = 23;
   localparam int LEN_W  = 6;

   logic              psram_sclk = 1'b0;
   logic              reset;
   logic              init_done;
   logic              lcd_req;
   logic              lcd_urgent;
   logic [ADDR_W-1:0] lcd_addr;
   logic              lcd_gnt;
   logic              mcu_req;
   logic              mcu_we;
   logic [LEN_W-1:0]  mcu_len;
   logic [ADDR_W-1:0] mcu_addr;
   logic              mcu_gnt;
   logic              eng_start;
   logic              eng_we;
   logic [ADDR_W-1:0] eng_addr;
   logic [LEN_W-1:0]  eng_len;
   logic              eng_done;
`ifdef PSRAM_ARB_STATS_EN
   logic [15:0]       lcd_grant_cnt;
   logic [15:0]       mcu_grant_cnt;
   logic [15:0]       urgent_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 psram_sclk = ~psram_sclk;

   psram_arbiter dut (
      .psram_sclk (psram_sclk),
      .reset      (reset),
      .init_done  (init_done),
      .lcd_req    (lcd_req),
      .lcd_urgent (lcd_urgent),
      .lcd_addr   (lcd_addr),
      .lcd_gnt    (lcd_gnt),
      .mcu_req    (mcu_req),
      .mcu_we     (mcu_we),
      .mcu_len    (mcu_len),
      .mcu_addr   (mcu_addr),
      .mcu_gnt    (mcu_gnt),
      .eng_start  (eng_start),
      .eng_we     (eng_we),
      .eng_addr   (eng_addr),
      .eng_len    (eng_len),
      .eng_done   (eng_done)
`ifdef PSRAM_ARB_STATS_EN
      ,
      .lcd_grant_cnt (lcd_grant_cnt),
      .mcu_grant_cnt (mcu_grant_cnt),
      .urgent_cnt    (urgent_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge psram_sclk);
      #1;
   endtask

   task automatic pulse_done();
      eng_done = 1'b1;
      tick(1);
      eng_done = 1'b0;
   endtask

   function automatic logic [63:0] outs();
      return 64'({lcd_gnt, mcu_gnt, eng_start, eng_we, eng_addr, eng_len});
   endfunction

   // waits for a grant, checks start latency, answers with eng_done after delay cycles
   task automatic run_burst(input int delay, output logic [1:0] who, output int idle);
      int n;
      n = 0;
      while (!(lcd_gnt || mcu_gnt) && n < 200) begin
         tick(1);
         n++;
      end
      chk("grant_arrives", 64'(n < 200), 64'(1));
      who  = {lcd_gnt, mcu_gnt};
      idle = n;
      n = 0;
      while (!eng_start && n < 5) begin
         tick(1);
         n++;
      end
      chk("start_latency", 64'(n), 64'(1));
      tick(delay);
      pulse_done();
   endtask

   // invariant monitors, sampled on the falling edge
   int viol_overlap = 0;
   int viol_orphan  = 0;
   int viol_starts  = 0;
   int viol_stable  = 0;
   int windows      = 0;
   int starts_in_win = 0;
   logic in_win = 1'b0;
   logic [ADDR_W+LEN_W:0] snap = '0;

   always @(negedge psram_sclk) begin
      if (lcd_gnt && mcu_gnt) viol_overlap <= viol_overlap + 1;
      if (eng_start && !(lcd_gnt || mcu_gnt)) viol_orphan <= viol_orphan + 1;
      if (lcd_gnt || mcu_gnt) begin
         if (!in_win) begin
            in_win        <= 1'b1;
            windows       <= windows + 1;
            starts_in_win <= eng_start ? 1 : 0;
            snap          <= {eng_we, eng_addr, eng_len};
         end else begin
            if ({eng_we, eng_addr, eng_len} != snap) viol_stable <= viol_stable + 1;
            if (eng_start) starts_in_win <= starts_in_win + 1;
         end
      end else if (in_win) begin
         in_win <= 1'b0;
         if (starts_in_win != 1) viol_starts <= viol_starts + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] who;
      int idle;
      int seen;
      int cd;
      int n;

      reset = 1'b1; init_done = 1'b0;
      lcd_req = 1'b0; lcd_urgent = 1'b0; lcd_addr = '0;
      mcu_req = 1'b0; mcu_we = 1'b0; mcu_len = '0; mcu_addr = '0;
      eng_done = 1'b0;
      tick(3);
      chk("reset_outputs", outs(), 64'd0);
`ifdef PSRAM_ARB_STATS_EN
      chk("reset_stats", 64'({lcd_grant_cnt, mcu_grant_cnt, urgent_cnt}), 64'd0);
`endif

      // requests ignored until init_done
      reset = 1'b0;
      lcd_req = 1'b1; lcd_addr = 23'h100;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (lcd_gnt || mcu_gnt || eng_start) seen++;
      end
      chk("wait_init_no_grant", 64'(seen), 64'd0);
      init_done = 1'b1;
      tick(2);
      chk("init_lcd_gnt", 64'(lcd_gnt), 64'd1);
      chk("init_mcu_gnt", 64'(mcu_gnt), 64'd0);
      chk("init_len", 64'(eng_len), 64'd16);
      chk("init_we", 64'(eng_we), 64'd0);
      chk("init_addr", 64'(eng_addr), 64'h100);
      chk("init_start_lag", 64'(eng_start), 64'd0);
      tick(1);
      chk("init_start", 64'(eng_start), 64'd1);
      tick(1);
      chk("init_start_single", 64'(eng_start), 64'd0);
      lcd_req = 1'b0;
      tick(3);
      chk("init_hold", 64'(lcd_gnt), 64'd1);
      pulse_done();
      chk("init_done_drop", 64'(lcd_gnt), 64'd0);

      // round robin: last owner LCD, so MCU first
      lcd_req = 1'b1; mcu_req = 1'b1; mcu_we = 1'b0; mcu_len = 6'd5; mcu_addr = 23'h2000;
      for (int i = 0; i < 4; i++) begin
         run_burst(10, who, idle);
         chk($sformatf("rr_owner_%0d", i), 64'(who), (i % 2 == 0) ? 64'b01 : 64'b10);
         chk($sformatf("rr_len_%0d", i), 64'(eng_len), (i % 2 == 0) ? 64'd5 : 64'd16);
         chk($sformatf("rr_gap_%0d", i), 64'(idle >= 4), 64'd1);
      end

      // MCU write with len 0, drop request mid-burst, stray done in ISSUE
      lcd_req = 1'b0; mcu_req = 1'b0;
      tick(8);
      mcu_req = 1'b1; mcu_we = 1'b1; mcu_len = 6'd0; mcu_addr = 23'h1234;
      tick(1);
      chk("mcu_gnt", 64'(mcu_gnt), 64'd1);
      chk("mcu_len0", 64'(eng_len), 64'd1);
      chk("mcu_we", 64'(eng_we), 64'd1);
      chk("mcu_addr", 64'(eng_addr), 64'h1234);
      eng_done = 1'b1;
      tick(1);
      eng_done = 1'b0;
      chk("mcu_start", 64'(eng_start), 64'd1);
      chk("mcu_done_in_issue_ignored", 64'(mcu_gnt), 64'd1);
      tick(1);
      mcu_req = 1'b0; mcu_addr = 23'h777; mcu_len = 6'd9; mcu_we = 1'b0;
      tick(5);
      chk("mcu_hold_gnt", 64'(mcu_gnt), 64'd1);
      chk("mcu_hold_cmd", 64'({eng_we, eng_addr, eng_len}), 64'({1'b1, 23'h1234, 6'd1}));
      pulse_done();
      chk("mcu_done_drop", 64'(mcu_gnt), 64'd0);

      // starvation: urgent LCD wins 8 times, then MCU is forced
      lcd_req = 1'b1; lcd_urgent = 1'b1; lcd_addr = 23'h300;
      mcu_req = 1'b1; mcu_we = 1'b0; mcu_len = 6'd2; mcu_addr = 23'h40;
      for (int i = 0; i < 19; i++) begin
         run_burst(3, who, idle);
         chk($sformatf("starve_owner_%0d", i), 64'(who), (i % 9 == 8) ? 64'b01 : 64'b10);
      end
`ifdef PSRAM_ARB_STATS_EN
      chk("stats_lcd", 64'(lcd_grant_cnt), 64'd20);
      chk("stats_mcu", 64'(mcu_grant_cnt), 64'd5);
      chk("stats_urgent", 64'(urgent_cnt), 64'd17);
`endif

      // reset during BUSY
      lcd_urgent = 1'b0; mcu_req = 1'b0;
      n = 0;
      while (!lcd_gnt && n < 50) begin
         tick(1);
         n++;
      end
      chk("rst_burst_grant", 64'(lcd_gnt), 64'd1);
      tick(3);
      #2;
      reset = 1'b1; init_done = 1'b0;
      #1;
      chk("rst_async_outputs", outs(), 64'd0);
`ifdef PSRAM_ARB_STATS_EN
      chk("rst_async_stats", 64'({lcd_grant_cnt, mcu_grant_cnt, urgent_cnt}), 64'd0);
`endif
      tick(1);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (lcd_gnt || mcu_gnt || eng_start) seen++;
      end
      chk("rst_no_grant_before_init", 64'(seen), 64'd0);
      init_done = 1'b1;
      tick(2);
      chk("rst_regrant", 64'(lcd_gnt), 64'd1);
      tick(3);
      lcd_req = 1'b0;
      pulse_done();

      // randomized traffic, invariants checked by the monitor
      cd = 0;
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 7) == 0) lcd_req = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) mcu_req = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) lcd_urgent = 1'($urandom_range(0, 1));
         mcu_we   = 1'($urandom_range(0, 1));
         mcu_len  = 6'($urandom);
         mcu_addr = 23'($urandom);
         lcd_addr = 23'($urandom);
         eng_done = 1'b0;
         if (eng_start) cd = $urandom_range(1, 12);
         else if (cd > 0) begin
            cd--;
            if (cd == 0) eng_done = 1'b1;
         end
         tick(1);
      end
      eng_done = 1'b0; lcd_req = 1'b0; mcu_req = 1'b0;
      if (lcd_gnt || mcu_gnt) begin
         tick(2);
         pulse_done();
      end
      tick(10);
      chk("inv_no_overlap", 64'(viol_overlap), 64'd0);
      chk("inv_start_inside_grant", 64'(viol_orphan), 64'd0);
      chk("inv_one_start_per_grant", 64'(viol_starts), 64'd0);
      chk("inv_cmd_stable", 64'(viol_stable), 64'd0);
      chk("inv_enough_grants", 64'(windows > 100), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
